dco_dither_therm: RTL and testbench



---
 rtl/dco_dither_therm.sv | 105 ++++++++++
 tb/tb_dco_dither_therm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dco_dither_therm.sv
// DCO varactor driver: sigma-delta dither of the fractional tuning word
// (1st order or MASH 1-1), saturated integer code plus thermometer decode.
module dco_dither_therm #(
    parameter int INT_W = 6,
    parameter int FRAC_W = 5,
    localparam int THERM_W = 2**INT_W - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sd_order,
    input  logic                    tune_valid,
    input  logic [INT_W+FRAC_W-1:0] tune_i,
    output logic [INT_W-1:0]        code_o,
    output logic [THERM_W-1:0]      therm_o,
    output logic                    sat_o
);

    logic [INT_W+FRAC_W-1:0] tune_q;
    logic [FRAC_W-1:0]       acc1, acc2;
    logic                    c2_d, sd_order_q;

    logic [INT_W-1:0]        int_p;
    logic [FRAC_W-1:0]       frac;
    logic [FRAC_W:0]         acc1n, acc2n;
    logic                    c1, c2, order_chg;
    logic signed [2:0]       d;
    logic signed [INT_W+1:0] s;

    logic [FRAC_W-1:0]       acc1_nx, acc2_nx;
    logic                    c2_d_nx, sat_nx;
    logic [INT_W-1:0]        code_nx;
    logic [THERM_W-1:0]      therm_nx;

    assign int_p = tune_q[INT_W+FRAC_W-1:FRAC_W];
    assign frac  = tune_q[FRAC_W-1:0];

    always_comb begin
        acc1n     = {1'b0, acc1} + {1'b0, frac};
        c1        = acc1n[FRAC_W];
        acc2n     = {1'b0, acc2} + {1'b0, acc1n[FRAC_W-1:0]};
        c2        = acc2n[FRAC_W];
        order_chg = (sd_order != sd_order_q);

        d       = '0;
        acc1_nx = '0;
        acc2_nx = '0;
        c2_d_nx = 1'b0;

        // A mode switch restarts the modulator from a clean state.
        if (!order_chg) begin
            acc1_nx = acc1n[FRAC_W-1:0];
            if (sd_order_q) begin
                acc2_nx = acc2n[FRAC_W-1:0];
                c2_d_nx = c2;
                d = $signed({2'b00, c1}) + $signed({2'b00, c2})
                  - $signed({2'b00, c2_d});
            end else begin
                d = $signed({2'b00, c1});
            end
        end

        s = $signed({2'b00, int_p}) + $signed({{(INT_W-1){d[2]}}, d});

        code_nx = s[INT_W-1:0];
        sat_nx  = 1'b0;
        if (s[INT_W+1]) begin
            code_nx = '0;
            sat_nx  = 1'b1;
        end else if (s[INT_W]) begin
            code_nx = '1;
            sat_nx  = 1'b1;
        end

        therm_nx = '0;
        for (int i = 0; i < THERM_W; i++) begin
            therm_nx[i] = (int'(code_nx) > i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tune_q     <= '0;
            acc1       <= '0;
            acc2       <= '0;
            c2_d       <= 1'b0;
            sd_order_q <= 1'b0;
            code_o     <= '0;
            therm_o    <= '0;
            sat_o      <= 1'b0;
        end else if (en) begin
            if (tune_valid) begin
                tune_q <= tune_i;
            end
            sd_order_q <= sd_order;
            acc1       <= acc1_nx;
            acc2       <= acc2_nx;
            c2_d       <= c2_d_nx;
            code_o     <= code_nx;
            therm_o    <= therm_nx;
            sat_o      <= sat_nx;
        end
    end

endmodule

// File: tb/tb_dco_dither_therm.sv
// Directed bench for dco_dither_therm: reset, integer-only, 1st order,
// MASH 1-1, mode switch, saturation at both ends, enable hold.
module tb_dco_dither_therm;

    logic        clk, rst, en, sd_order, tune_valid;
    logic [10:0] tune_i;
    logic [5:0]  code_o;
    logic [62:0] therm_o;
    logic        sat_o;

    int vecs = 0;
    int errs = 0;
    int sum, ones, e;
    logic [31:0] code_mask, sat_mask;

    dco_dither_therm dut (
        .clk(clk), .rst(rst), .en(en), .sd_order(sd_order),
        .tune_valid(tune_valid), .tune_i(tune_i),
        .code_o(code_o), .therm_o(therm_o), .sat_o(sat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] th(input int c);
        return (64'd1 << c) - 64'd1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int c, input logic s);
        chk({tag, "_code"}, 64'(code_o), 64'(c));
        chk({tag, "_therm"}, {1'b0, therm_o}, th(c));
        chk({tag, "_sat"}, 64'(sat_o), 64'(s));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_out(tag, 0, 1'b0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; en = 1'b0; sd_order = 1'b0;
        tune_valid = 1'b0; tune_i = '0;
        #12;
        chk_out("por", 0, 1'b0);
        rst = 1'b0;
        en = 1'b1;
        repeat (3) begin
            tick;
            chk_out("post_rst", 0, 1'b0);
        end

        // Integer only: int=10, frac=0
        tune_i = {6'd10, 5'd0}; tune_valid = 1'b1;
        tick;
        tune_valid = 1'b0;
        chk_out("int_lat", 0, 1'b0);
        repeat (4) begin
            tick;
            chk_out("int_only", 10, 1'b0);
        end

        // 1st order int=10 frac=8: 10,10,10,11 repeating
        do_reset("rst1");
        tune_i = {6'd10, 5'd8}; tune_valid = 1'b1;
        tick;
        tune_valid = 1'b0;
        chk_out("o1_lat", 0, 1'b0);
        sum = 0; ones = 0;
        for (int i = 0; i < 32; i++) begin
            tick;
            e = (i % 4 == 3) ? 11 : 10;
            chk("o1_code", 64'(code_o), 64'(e));
            sum += int'(code_o);
            if (code_o == 6'd11) ones++;
        end
        chk("o1_sum", 64'(sum), 64'd328);
        chk("o1_ones", 64'(ones), 64'd8);
        for (int i = 32; i < 34; i++) begin
            tick;
            chk("o1_pre_hold", 64'(code_o), 64'd10);
        end
        en = 1'b0;
        repeat (5) begin
            tick;
            chk_out("hold", 10, 1'b0);
        end
        en = 1'b1;
        ones = 0;
        for (int i = 34; i < 66; i++) begin
            tick;
            e = (i % 4 == 3) ? 11 : 10;
            chk("o1_resume", 64'(code_o), 64'(e));
            if (code_o == 6'd11) ones++;
        end
        chk("o1_resume_ones", 64'(ones), 64'd8);

        // MASH 1-1 int=10 frac=16: 10,11,11,10 repeating
        do_reset("rst2");
        sd_order = 1'b1;
        tune_i = {6'd10, 5'd16}; tune_valid = 1'b1;
        tick;
        tune_valid = 1'b0;
        chk_out("m2_lat", 0, 1'b0);
        sum = 0;
        for (int i = 0; i < 64; i++) begin
            tick;
            e = (i % 4 == 1 || i % 4 == 2) ? 11 : 10;
            chk("m2_code", 64'(code_o), 64'(e));
            chk("m2_range", 64'(code_o >= 6'd9 && code_o <= 6'd12), 64'd1);
            sum += int'(code_o);
        end
        chk("m2_sum", 64'(sum >= 671 && sum <= 673), 64'd1);
        tick;
        chk("m2_64", 64'(code_o), 64'd10);
        sd_order = 1'b0;
        tick;
        chk_out("switch_d0", 10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick;
            e = (i % 2 == 1) ? 11 : 10;
            chk("switch_o1", 64'(code_o), 64'(e));
        end

        // Low saturation: int=0 frac=1, MASH
        code_mask = 32'h044A_A480;
        sat_mask  = 32'h0225_4900;
        do_reset("rst3");
        sd_order = 1'b1;
        tune_i = {6'd0, 5'd1}; tune_valid = 1'b1;
        tick;
        tune_valid = 1'b0;
        chk_out("lo_lat", 0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            tick;
            chk_out("lo_sat", int'(code_mask[i]), sat_mask[i]);
        end

        // High saturation: int=63 frac=31, 1st order
        do_reset("rst4");
        sd_order = 1'b0;
        tune_i = {6'd63, 5'd31}; tune_valid = 1'b1;
        tick;
        tune_valid = 1'b0;
        chk_out("hi_lat", 0, 1'b0);
        for (int i = 0; i < 34; i++) begin
            tick;
            chk_out("hi_sat", 63, (i % 32) != 0);
        end

        // Mid-run async reset, then no new word: stays at zero
        do_reset("rst_mid");
        repeat (3) begin
            tick;
            chk_out("rst_mid_hold", 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
